// File: rtl/camera_pixel_reconstruct_pkg.sv
// Shared types and default geometry for the camera pixel reconstruction block.
package camera_pkg;

    localparam int DEFAULT_H_RES = 320;
    localparam int DEFAULT_V_RES = 240;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        BYTE_HI    = 2'd1,
        BYTE_LO    = 2'd2
    } state_t;

    typedef struct packed {
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
    } rgb565_t;

endpackage

// File: rtl/camera_pixel_reconstruct_if.sv
// Camera byte bus in, reconstructed pixel bus out; slave modport is the reconstruct block.
interface camera_pixel_reconstruct_if #(
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10
);
    logic                    camera_pclk_in;
    logic                    camera_hs_in;
    logic                    camera_vs_in;
    logic [7:0]              camera_data_in;
    logic                    pixel_valid_out;
    logic [HCOUNT_WIDTH-1:0] pixel_hcount_out;
    logic [VCOUNT_WIDTH-1:0] pixel_vcount_out;
    logic [4:0]              pixel_red_out;
    logic [5:0]              pixel_green_out;
    logic [4:0]              pixel_blue_out;
    logic                    frame_start_out;

    modport master (
        output camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
        input  pixel_valid_out, pixel_hcount_out, pixel_vcount_out,
        input  pixel_red_out, pixel_green_out, pixel_blue_out, frame_start_out
    );

    modport slave (
        input  camera_pclk_in, camera_hs_in, camera_vs_in, camera_data_in,
        output pixel_valid_out, pixel_hcount_out, pixel_vcount_out,
        output pixel_red_out, pixel_green_out, pixel_blue_out, frame_start_out
    );

endinterface

// File: rtl/camera_pixel_reconstruct_edge_detect.sv
// Registered rise/fall detector; the reference sample only updates when en is high.
module edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sig,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else if (en) begin
            prev <= sig;
        end
    end

    assign rise = en & sig & ~prev;
    assign fall = en & ~sig & prev;

endmodule

// File: rtl/camera_pixel_reconstruct.sv
// RGB565 reassembly from an 8-bit camera bus with column/row tracking.
// Build option CAMERA_BYTE_SWAP_EN: first byte of each pair is the low byte.
module camera_pixel_reconstruct
    import camera_pkg::*;
#(
    parameter int H_RES        = DEFAULT_H_RES,
    parameter int V_RES        = DEFAULT_V_RES,
    parameter int HCOUNT_WIDTH = 10,
    parameter int VCOUNT_WIDTH = 10
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    camera_pixel_reconstruct_if.slave   bus
);

    function automatic logic [HCOUNT_WIDTH-1:0] hcount_inc(input logic [HCOUNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(HCOUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [VCOUNT_WIDTH-1:0] vcount_inc(input logic [VCOUNT_WIDTH-1:0] c);
        return (&c) ? c : c + {{(VCOUNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic pclk_rise, pclk_fall;
    logic hs_rise, hs_fall;
    logic vs_rise, vs_fall;
    logic unused_edges;

    edge_detect u_pclk_edge (
        .clk  (clk_in),
        .rst  (rst_in),
        .en   (1'b1),
        .sig  (bus.camera_pclk_in),
        .rise (pclk_rise),
        .fall (pclk_fall)
    );

    edge_detect u_hs_edge (
        .clk  (clk_in),
        .rst  (rst_in),
        .en   (pclk_rise),
        .sig  (bus.camera_hs_in),
        .rise (hs_rise),
        .fall (hs_fall)
    );

    edge_detect u_vs_edge (
        .clk  (clk_in),
        .rst  (rst_in),
        .en   (pclk_rise),
        .sig  (bus.camera_vs_in),
        .rise (vs_rise),
        .fall (vs_fall)
    );

    assign unused_edges = pclk_fall ^ hs_rise ^ vs_rise;

    state_t state, state_next;
    logic   latch_hi, emit, clr_frame, line_end;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= WAIT_FRAME;
        end else begin
            state <= state_next;
        end
    end

    // Frame sync dominates line activity; line end drops any half-formed pixel.
    always_comb begin
        state_next = state;
        latch_hi   = 1'b0;
        emit       = 1'b0;
        clr_frame  = 1'b0;
        line_end   = 1'b0;
        if (pclk_rise) begin
            if (state == WAIT_FRAME) begin
                if (vs_fall) begin
                    clr_frame  = 1'b1;
                    state_next = BYTE_HI;
                end
            end else if (bus.camera_vs_in) begin
                clr_frame  = 1'b1;
                state_next = BYTE_HI;
            end else if (hs_fall) begin
                line_end   = 1'b1;
                state_next = BYTE_HI;
            end else if (bus.camera_hs_in) begin
                if (state == BYTE_HI) begin
                    latch_hi   = 1'b1;
                    state_next = BYTE_LO;
                end else if (state == BYTE_LO) begin
                    emit       = 1'b1;
                    state_next = BYTE_HI;
                end else begin
                    state_next = WAIT_FRAME;
                end
            end
        end
    end

    // Stage p0: first byte of the pair held until its partner arrives
    logic [7:0] first_byte_p0;

    always_ff @(posedge clk_in) begin
        if (latch_hi) begin
            first_byte_p0 <= bus.camera_data_in;
        end
    end

    rgb565_t pixel_word;
    logic    in_range;

`ifdef CAMERA_BYTE_SWAP_EN
    assign pixel_word = rgb565_t'({bus.camera_data_in, first_byte_p0});
`else
    assign pixel_word = rgb565_t'({first_byte_p0, bus.camera_data_in});
`endif

    logic [HCOUNT_WIDTH-1:0] hcount;
    logic [VCOUNT_WIDTH-1:0] vcount;

    assign in_range = (int'(hcount) < H_RES) && (int'(vcount) < V_RES);

    // Stage p1: registered pixel presentation, one cycle after the low-byte edge
    logic                    vld_p1;
    logic                    frame_start_p1;
    rgb565_t                 pixel_p1;
    logic [HCOUNT_WIDTH-1:0] hcount_p1;
    logic [VCOUNT_WIDTH-1:0] vcount_p1;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hcount         <= '0;
            vcount         <= '0;
            vld_p1         <= 1'b0;
            frame_start_p1 <= 1'b0;
            pixel_p1       <= '0;
            hcount_p1      <= '0;
            vcount_p1      <= '0;
        end else begin
            vld_p1         <= 1'b0;
            frame_start_p1 <= pclk_rise & vs_fall;
            if (clr_frame) begin
                hcount <= '0;
                vcount <= '0;
            end
            if (line_end) begin
                hcount <= '0;
                vcount <= vcount_inc(vcount);
            end
            if (emit) begin
                hcount <= hcount_inc(hcount);
                if (in_range) begin
                    vld_p1    <= 1'b1;
                    pixel_p1  <= pixel_word;
                    hcount_p1 <= hcount;
                    vcount_p1 <= vcount;
                end
            end
        end
    end

    assign bus.pixel_valid_out  = vld_p1;
    assign bus.frame_start_out  = frame_start_p1;
    assign bus.pixel_hcount_out = hcount_p1;
    assign bus.pixel_vcount_out = vcount_p1;
    assign bus.pixel_red_out    = pixel_p1.r;
    assign bus.pixel_green_out  = pixel_p1.g;
    assign bus.pixel_blue_out   = pixel_p1.b;

endmodule

// File: tb/tb_camera_pixel_reconstruct.sv
// Randomized and directed bench for camera_pixel_reconstruct with an in-bench byte-stream model.
module tb_camera_pixel_reconstruct;
    import camera_pkg::*;

    localparam int H_RES = 320;
    localparam int V_RES = 240;
    localparam int HW    = 10;
    localparam int VW    = 10;
    localparam int HMAX  = (1 << HW) - 1;
    localparam int VMAX  = (1 << VW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    camera_pixel_reconstruct_if #(.HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)) bus ();

    camera_pixel_reconstruct #(
        .H_RES(H_RES), .V_RES(V_RES), .HCOUNT_WIDTH(HW), .VCOUNT_WIDTH(VW)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected output events keyed by the cycle they must appear in.
    typedef struct {
        bit valid;
        bit fs;
        bit rst;
        int r, g, b, h, v;
    } exp_t;
    exp_t exp_map[int];

    typedef struct {
        int r, g, b, h, v;
    } obs_t;
    obs_t obs[$];
    int   fs_seen = 0;

    // Model: byte index within the line decides pairing and column.
    bit         armed;
    bit         prev_hs, prev_vs;
    int         k, row;
    logic [7:0] first;

    function automatic exp_t get_exp(input int key);
        exp_t e;
        e = '{default: 0};
        if (exp_map.exists(key)) e = exp_map[key];
        return e;
    endfunction

    function automatic void model_reset();
        armed   = 1'b0;
        prev_hs = 1'b0;
        prev_vs = 1'b0;
        k       = 0;
        row     = 0;
    endfunction

    function automatic void model_edge(input bit hs, input bit vs, input logic [7:0] d, input int key);
        bit          fs;
        logic [15:0] w;
        int          col;
        exp_t        e;
        fs = prev_vs && !vs;
        if (fs) begin
            e = get_exp(key);
            e.fs = 1'b1;
            exp_map[key] = e;
        end
        if (!armed) begin
            if (fs) begin
                armed = 1'b1;
                k     = 0;
                row   = 0;
            end
        end else if (vs) begin
            k   = 0;
            row = 0;
        end else if (!hs && prev_hs) begin
            k   = 0;
            row = (row >= VMAX) ? VMAX : row + 1;
        end else if (hs) begin
            if (k % 2 == 0) begin
                first = d;
            end else begin
`ifdef CAMERA_BYTE_SWAP_EN
                w = {d, first};
`else
                w = {first, d};
`endif
                col = (k - 1) / 2;
                if (col > HMAX) col = HMAX;
                if (col < H_RES && row < V_RES) begin
                    e = get_exp(key);
                    e.valid = 1'b1;
                    e.r = int'(w[15:11]);
                    e.g = int'(w[10:5]);
                    e.b = int'(w[4:0]);
                    e.h = col;
                    e.v = row;
                    exp_map[key] = e;
                end
            end
            k++;
        end
        prev_hs = hs;
        prev_vs = vs;
    endfunction

    // Compare process: every cycle, outputs must match the model's event stream.
    bit   checking = 1'b0;
    int   held_r = 0, held_g = 0, held_b = 0, held_h = 0, held_v = 0;
    exp_t ce;
    always @(negedge clk) begin
        if (checking) begin
            ce = get_exp(cyc);
            if (exp_map.exists(cyc)) exp_map.delete(cyc);
            if (ce.rst) begin
                held_r = 0; held_g = 0; held_b = 0; held_h = 0; held_v = 0;
            end
            if (ce.valid) begin
                held_r = ce.r; held_g = ce.g; held_b = ce.b; held_h = ce.h; held_v = ce.v;
            end
            check("valid",       int'(bus.pixel_valid_out),  int'(ce.valid));
            check("frame_start", int'(bus.frame_start_out),  int'(ce.fs));
            check("red",         int'(bus.pixel_red_out),    held_r);
            check("green",       int'(bus.pixel_green_out),  held_g);
            check("blue",        int'(bus.pixel_blue_out),   held_b);
            check("hcount",      int'(bus.pixel_hcount_out), held_h);
            check("vcount",      int'(bus.pixel_vcount_out), held_v);
            if (bus.pixel_valid_out)
                obs.push_back('{int'(bus.pixel_red_out), int'(bus.pixel_green_out),
                                int'(bus.pixel_blue_out), int'(bus.pixel_hcount_out),
                                int'(bus.pixel_vcount_out)});
            if (bus.frame_start_out) fs_seen++;
        end
    end

    // One pclk rising edge carrying hs/vs/data, with random low/high phase lengths.
    task automatic edge_byte(input bit hs, input bit vs, input logic [7:0] d);
        int lo;
        lo = $urandom_range(1, 3);
        @(posedge clk); #1;
        bus.camera_pclk_in = 1'b0;
        bus.camera_hs_in   = hs;
        bus.camera_vs_in   = vs;
        bus.camera_data_in = d;
        for (int i = 1; i < lo; i++) begin
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.camera_pclk_in = 1'b1;
        model_edge(hs, vs, d, cyc + 1);
        if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send_pixel(input logic [7:0] hi, input logic [7:0] lo);
`ifdef CAMERA_BYTE_SWAP_EN
        edge_byte(1'b1, 1'b0, lo);
        edge_byte(1'b1, 1'b0, hi);
`else
        edge_byte(1'b1, 1'b0, hi);
        edge_byte(1'b1, 1'b0, lo);
`endif
    endtask

    task automatic send_rand_pixel();
        send_pixel(8'($urandom), 8'($urandom));
    endtask

    task automatic line_end();
        edge_byte(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic vsync(input bit rand_hs);
        int n;
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++)
            edge_byte(rand_hs ? 1'($urandom) : 1'b0, 1'b1, 8'($urandom));
        edge_byte(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic flush();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_obs(input string name, input int idx,
                             input int r, input int g, input int b, input int h, input int v);
        if (idx < obs.size()) begin
            check({name, "_r"}, obs[idx].r, r);
            check({name, "_g"}, obs[idx].g, g);
            check({name, "_b"}, obs[idx].b, b);
            check({name, "_h"}, obs[idx].h, h);
            check({name, "_v"}, obs[idx].v, v);
        end else begin
            check({name, "_present"}, obs.size(), idx + 1);
        end
    endtask

    task automatic do_reset();
        exp_t e;
        @(posedge clk); #1;
        rst = 1'b1;
        bus.camera_pclk_in = 1'b0;
        bus.camera_hs_in   = 1'b0;
        bus.camera_vs_in   = 1'b0;
        e = get_exp(cyc + 1);
        e.rst = 1'b1;
        exp_map[cyc + 1] = e;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check("midrst_valid",  int'(bus.pixel_valid_out),  0);
        check("midrst_hcount", int'(bus.pixel_hcount_out), 0);
        check("midrst_vcount", int'(bus.pixel_vcount_out), 0);
        check("midrst_red",    int'(bus.pixel_red_out),    0);
        check("midrst_green",  int'(bus.pixel_green_out),  0);
        check("midrst_blue",   int'(bus.pixel_blue_out),   0);
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    int fs_base;
    int npix;

    initial begin
        bus.camera_pclk_in = 1'b0;
        bus.camera_hs_in   = 1'b0;
        bus.camera_vs_in   = 1'b0;
        bus.camera_data_in = 8'h00;
        model_reset();
        first = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid",  int'(bus.pixel_valid_out),  0);
        check("rst_fs",     int'(bus.frame_start_out),  0);
        check("rst_hcount", int'(bus.pixel_hcount_out), 0);
        check("rst_vcount", int'(bus.pixel_vcount_out), 0);
        check("rst_red",    int'(bus.pixel_red_out),    0);
        check("rst_green",  int'(bus.pixel_green_out),  0);
        check("rst_blue",   int'(bus.pixel_blue_out),   0);
        @(posedge clk); #1;
        checking = 1'b1;
        rst = 1'b0;

        // Bytes before any frame sync fall are discarded.
        obs.delete();
        for (int i = 0; i < 4; i++) send_rand_pixel();
        line_end();
        send_rand_pixel();
        flush();
        check("pre_vs_strobes", obs.size(), 0);
        check("pre_vs_fs", fs_seen, 0);

        vsync(1'b0);
        flush();
        check("fs_once", fs_seen, 1);

        // Primary colours on line 0, then further lines.
        obs.delete();
        send_pixel(8'hF8, 8'h00);
        send_pixel(8'h07, 8'hE0);
        send_pixel(8'h00, 8'h1F);
        send_pixel(8'hFF, 8'hFF);
        line_end();
        send_pixel(8'h12, 8'h34);
        send_pixel(8'h56, 8'h78);
        line_end();
        send_pixel(8'hAB, 8'hCD);
        edge_byte(1'b1, 1'b0, 8'hEE);
        line_end();
        send_pixel(8'hF8, 8'h00);
        line_end();
        flush();
        check("line_pixels", obs.size(), 8);
        check_obs("px_red",   0, 31,  0,  0, 0, 0);
        check_obs("px_green", 1,  0, 63,  0, 1, 0);
        check_obs("px_blue",  2,  0,  0, 31, 2, 0);
        check_obs("px_white", 3, 31, 63, 31, 3, 0);
        check_obs("l1_p0",    4,  2, 17, 20, 0, 1);
        check_obs("l1_p1",    5, 10, 51, 24, 1, 1);
        check_obs("odd_l2",   6, 21, 30, 13, 0, 2);
        check_obs("after_odd",7, 31,  0,  0, 0, 3);

        // Overlong line: only H_RES strobes.
        vsync(1'b0);
        obs.delete();
        for (int i = 0; i < H_RES + 2; i++) send_rand_pixel();
        line_end();
        flush();
        check("hres_count", obs.size(), H_RES);
        if (obs.size() > 0) begin
            check("hres_last_h", obs[obs.size()-1].h, H_RES - 1);
            check("hres_last_v", obs[obs.size()-1].v, 0);
        end

        // Overlong frame: only V_RES lines produce strobes.
        vsync(1'b0);
        obs.delete();
        for (int l = 0; l < V_RES + 2; l++) begin
            send_rand_pixel();
            line_end();
        end
        flush();
        check("vres_count", obs.size(), V_RES);
        if (obs.size() > 0) begin
            check("vres_last_v", obs[obs.size()-1].v, V_RES - 1);
            check("vres_last_h", obs[obs.size()-1].h, 0);
        end

        // Reset mid-line: silence until next frame sync fall.
        vsync(1'b0);
        send_pixel(8'hF8, 8'h00);
        edge_byte(1'b1, 1'b0, 8'h55);
        do_reset();
        obs.delete();
        fs_base = fs_seen;
        for (int i = 0; i < 3; i++) send_rand_pixel();
        line_end();
        send_rand_pixel();
        flush();
        check("postrst_strobes", obs.size(), 0);
        vsync(1'b0);
        send_pixel(8'h07, 8'hE0);
        line_end();
        flush();
        check("postrst_fs", fs_seen - fs_base, 1);
        check("postrst_count", obs.size(), 1);
        check_obs("postrst_px", 0, 0, 63, 0, 0, 0);

        // Randomized frames, including vs/hs overlap and odd bytes.
        for (int f = 0; f < 6; f++) begin
            vsync(1'b1);
            for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
                npix = $urandom_range(0, 6);
                for (int p = 0; p < npix; p++) send_rand_pixel();
                if ($urandom_range(0, 3) == 0) edge_byte(1'b1, 1'b0, 8'($urandom));
                if ($urandom_range(0, 9) == 0) edge_byte(1'($urandom), 1'b1, 8'($urandom));
                line_end();
            end
            if ($urandom_range(0, 4) == 0) do_reset();
        end
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/camera_pixel_reconstruct.md
Name: camera_pixel_reconstruct

Overview:
Reassembles RGB565 pixels from an 8-bit parallel camera bus (two bytes per pixel) sampled in the system clock domain.
Generates pixel coordinates and a one-cycle valid strobe.
Sits directly upstream of the 565-to-888 colour conversion stage. Its red/green/blue fields connect straight into that stage's 5/6/5-bit inputs.

Parameters:
H_RES, 320, active pixels per line; pixels at or beyond this column are suppressed.
V_RES, 240, active lines per frame; lines at or beyond this row are suppressed.
HCOUNT_WIDTH, 10, width of the column counter.
VCOUNT_WIDTH, 10, width of the row counter.

Ports:
clk_in  input  1  system clock; all logic runs on its rising edge.
rst_in  input  1  reset, synchronous and active-high.
camera_pclk_in  input  1  camera pixel clock, already synchronised into clk_in; treated as data, never used as a clock.
camera_hs_in  input  1  line-valid (high while line bytes are present); synchronised.
camera_vs_in  input  1  frame sync (high during vertical blanking); synchronised.
camera_data_in  input  8  camera byte; synchronised.
pixel_valid_out  output  1  one-cycle strobe; a complete in-range pixel is present.
pixel_hcount_out  output  HCOUNT_WIDTH  column of the presented pixel.
pixel_vcount_out  output  VCOUNT_WIDTH  row of the presented pixel.
pixel_red_out  output  5  pixel bits [15:11].
pixel_green_out  output  6  pixel bits [10:5].
pixel_blue_out  output  5  pixel bits [4:0].
frame_start_out  output  1  one-cycle strobe on the falling edge of camera_vs_in, sampled at a pclk edge.

Behaviour:
- pclk edge: asserted in the cycle where camera_pclk_in=1 and the registered previous pclk sample=0. hs, vs and data are sampled in that same cycle. Nothing advances in cycles without a pclk edge.
- FSM states: WAIT_FRAME, BYTE_HI, BYTE_LO. Reset state is WAIT_FRAME.
- WAIT_FRAME: on a pclk edge with vs=0 and the previous vs=1, go to BYTE_HI and pulse frame_start_out. Any other pclk edge keeps WAIT_FRAME. This discards the partial frame seen after reset.
- Any pclk edge with vs=1, from any state other than WAIT_FRAME: hcount=0, vcount=0, state goes to BYTE_HI.
- BYTE_HI, pclk edge, vs=0, hs=1: latch the byte as the high byte, go to BYTE_LO.
- BYTE_LO, pclk edge, vs=0, hs=1: form {hi, data}. Next cycle pixel_valid_out=1 with the current hcount/vcount. Then hcount increments, saturating at all-ones. Go to BYTE_HI.
- Pixel suppression: the pixel is suppressed (no valid) when hcount>=H_RES or vcount>=V_RES. Counters still advance.
- pclk edge with hs=0 while the previous sampled hs=1 (line end): hcount=0, vcount+1 (saturating), state BYTE_HI. A dangling high byte is dropped, with no pixel emitted.
- Latency: exactly 1 clk_in cycle from the pclk edge carrying the low byte to pixel_valid_out.
- Output hold: data, colour fields and counts hold their values between strobes.
- Reset values of all outputs: 0.
- Reset mid-line: all state clears, and output resumes only after the next vs falling edge.
- Simultaneous vs=1 and hs=1: vs wins.

Optional Feature:
CAMERA_BYTE_SWAP_EN
- Defined: the first byte of each pair is the low byte (pixel = {second, first}).
- Undefined: the first byte is the high byte.
- Timing and counters are identical in both builds.

Decomposition:
- Package camera_pkg holds:
  - the state enum (WAIT_FRAME, BYTE_HI, BYTE_LO);
  - the rgb565 packed struct (r[4:0], g[5:0], b[4:0]);
  - the default H_RES/V_RES localparams.
- Sub-module edge_detect: registered rising/falling detector, instantiated for pclk, vs and hs.

Test Plan:
- Reset, vs pulse, then one line of 4 pixels; bytes F8,00,07,E0,00,1F,FF,FF with hs=1 → valid strobes with (r,g,b)=(31,0,0)@h0, (0,63,0)@h1, (0,0,31)@h2, (31,63,31)@h3, all at v0; each valid exactly 1 cycle after its low-byte pclk edge.
- Two lines separated by hs low → second line pixels report v=1 with h restarting at 0.
- hs drops after 3 bytes → 1 pixel emitted, odd byte dropped; next line's first pixel is correct at h0.
- Line of H_RES+2 pixels → exactly H_RES strobes; last strobe at h=H_RES-1.
- Bytes streamed before any vs falling edge → no strobes. After vs falls, frame_start_out pulses once and pixels start at (0,0).
- rst_in asserted mid-line → all outputs 0 next cycle; no strobes until the next vs falling edge.
- CAMERA_BYTE_SWAP_EN build: bytes 00,F8 → (31,0,0).
